// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: loader state encoding and the
// default frame geometry used by fft_stage and sample_loader.
package fft_pkg;

    localparam int WORDSIZE_DEF   = 16;
    localparam int ADDRSIZE_DEF   = 8;
    localparam int NUMSAMPLES_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    // Samples are striped across four banks, so the low two counter bits pick the bank.
    function automatic logic [3:0] bank_onehot(input logic [1:0] sel);
        bank_onehot = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/sample_loader_bank_addr_gen.sv
// Maps a frame sample counter onto the four-bank layout: sample n lands in
// bank n[1:0] at row n>>2.
module bank_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int CNTW     = 6
) (
    input  logic [CNTW-1:0]     cnt_i,
    output logic [3:0]          bank_oh_o,
    output logic [ADDRSIZE-1:0] addr_o
);

    assign bank_oh_o = bank_onehot(cnt_i[1:0]);
    assign addr_o    = ADDRSIZE'(cnt_i >> 2);

endmodule

// File: rtl/sample_loader.sv
// Streams one frame of samples into four interleaved bank RAMs and hands the
// frame over to the FFT stage through ld_done.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for ld_data; in_valid ignored
//   ST_LOAD | accepting samples, one registered bank write per beat
//   ST_DONE | whole frame in RAM, ld_done high until ld_data drops
module sample_loader
    import fft_pkg::*;
#(
    parameter int WORDSIZE   = WORDSIZE_DEF,
    parameter int ADDRSIZE   = ADDRSIZE_DEF,
    parameter int NUMSAMPLES = NUMSAMPLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_data,
    input  logic                in_valid,
    input  logic [WORDSIZE-1:0] in_data,
    output logic                in_ready,
    output logic [3:0]          wr_en,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [WORDSIZE-1:0] wr_data,
    output logic                ld_done,
    output logic                init_error
);

    // One extra bit so the counter can never wrap inside a frame.
    localparam int              CNTW      = $clog2(NUMSAMPLES) + 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NUMSAMPLES - 1);

    ld_state_e           state_q;
    logic [CNTW-1:0]     cnt_q;
    logic [3:0]          wr_en_q;
    logic [ADDRSIZE-1:0] wr_addr_q;
    logic [WORDSIZE-1:0] wr_data_q;
    logic                ld_done_q;
    logic                init_error_q;

    logic [3:0]          gen_bank;
    logic [ADDRSIZE-1:0] gen_addr;
    logic                accept;

    bank_addr_gen #(
        .ADDRSIZE (ADDRSIZE),
        .CNTW     (CNTW)
    ) u_bank_addr_gen (
        .cnt_i     (cnt_q),
        .bank_oh_o (gen_bank),
        .addr_o    (gen_addr)
    );

    assign in_ready   = (state_q == ST_LOAD);
    assign accept     = in_valid && in_ready;

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign ld_done    = ld_done_q;
    assign init_error = init_error_q;

    // Load sequencer; the write port and status flags are registered so the
    // final write and ld_done appear on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            ld_done_q    <= 1'b0;
            init_error_q <= 1'b0;
        end else begin
            wr_en_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (ld_data) begin
                        state_q      <= ST_LOAD;
                        cnt_q        <= '0;
                        init_error_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // The last beat completes the frame even if ld_data drops with it.
                    if (accept && (cnt_q == LAST_BEAT)) begin
                        wr_en_q   <= gen_bank;
                        wr_addr_q <= gen_addr;
                        wr_data_q <= in_data;
                        cnt_q     <= cnt_q + CNTW'(1);
                        ld_done_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (!ld_data) begin
                        init_error_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (accept) begin
                        wr_en_q   <= gen_bank;
                        wr_addr_q <= gen_addr;
                        wr_data_q <= in_data;
                        cnt_q     <= cnt_q + CNTW'(1);
                    end
                end
                ST_DONE: begin
                    if (!ld_data) begin
                        ld_done_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter WORDSIZE, default 16, sample width in bits.
REQ-002 Parameter ADDRSIZE, default 8, bank RAM address width.
REQ-003 Parameter NUMSAMPLES, default 32, samples per frame; a multiple of 4, with NUMSAMPLES/4 <= 2^ADDRSIZE.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ld_data  in  1  level request to load one frame into the four banks.
REQ-007 in_valid  in  1  in_data carries a sample.
REQ-008 in_data  in  WORDSIZE  sample, natural time order.
REQ-009 in_ready  out  1  loader accepts a sample this cycle.
REQ-010 wr_en  out  4  one-hot bank write strobe; bit k selects bank k.
REQ-011 wr_addr  out  ADDRSIZE  bank write address, shared by all banks.
REQ-012 wr_data  out  WORDSIZE  bank write data, shared by all banks.
REQ-013 ld_done  out  1  frame fully written; drives the stage ld_done input.
REQ-014 init_error  out  1  sticky flag: the frame load was aborted.

Function
REQ-015 States: IDLE, LOAD, DONE; encoding in the shared package.
REQ-016 IDLE -> LOAD when ld_data=1; sample counter cleared to 0 and init_error cleared on the same edge.
REQ-017 in_ready = 1 only in LOAD; a beat is accepted when in_valid & in_ready.
REQ-018 Accepted beat n (n = 0..NUMSAMPLES-1) is written to bank n[1:0] at address n>>2 (zero-extended to ADDRSIZE).
REQ-019 Write latency is exactly one cycle: wr_en, wr_addr and wr_data are registered and valid the cycle after acceptance.
REQ-020 wr_en = 0 in any cycle following no acceptance; wr_addr and wr_data hold their last values.
REQ-021 Counter increments only on acceptance; in_valid gaps stall without loss or duplication.
REQ-022 LOAD -> DONE on the cycle after beat NUMSAMPLES-1 is accepted; in_ready = 0 from that cycle on.
REQ-023 ld_done = 1 in DONE, registered, asserted in the same cycle as the final wr_en pulse, so the last word is in RAM when the stage samples ld_done.
REQ-024 DONE -> IDLE when ld_data=0; ld_done falls on the same edge.
REQ-025 DONE holds while ld_data=1; a new frame requires ld_data low for at least one cycle.
REQ-026 ld_data=0 while in LOAD: abort; go to IDLE, set init_error=1, ld_done stays 0, no further writes; the counter is not wrapped.
REQ-027 ld_data falling in the same cycle as acceptance of the last beat: that beat is written, the state goes to DONE, init_error stays 0.
REQ-028 in_valid in IDLE or DONE: ignored, no write, no error.
REQ-029 Counter width is clog2(NUMSAMPLES)+1; it never wraps within a frame.

Reset
REQ-030 rst_n=0 forces immediately: state IDLE, counter 0, wr_en 0, wr_addr 0, wr_data 0, ld_done 0, init_error 0, in_ready 0.
REQ-031 Reset mid-LOAD discards the partial frame without setting init_error; the banks are not cleared.
REQ-032 Deassertion is sampled by the clock; the first transition is allowed on the first rising edge with rst_n=1.

Structure
REQ-033 Shared package fft_pkg holds the state encoding and the WORDSIZE/ADDRSIZE/NUMSAMPLES defaults used by fft_stage and sample_loader.
REQ-034 A single sub-module bank_addr_gen maps counter -> {bank one-hot, address}; everything else stays flat.
REQ-035 No tri-state outputs; the block is always enabled.

Verification
REQ-036 Reset, ld_data=1, 32 back-to-back beats 0x0000..0x001F -> bank k receives values 4a+k at address a; ld_done rises with the 32nd write.
REQ-037 Same frame with in_valid toggling 1010 -> identical bank contents; one wr_en pulse per accepted beat, total 32.
REQ-038 ld_data dropped after 10 beats -> IDLE, init_error=1, exactly 10 writes; a following full load clears init_error.
REQ-039 ld_data held high 5 cycles after DONE -> ld_done stays 1, in_ready=0, no writes; ld_data=0 -> ld_done=0 next edge.
REQ-040 rst_n pulsed low after beat 17 -> all outputs 0 immediately, init_error=0; a restarted frame writes bank 0 at address 0 first.
REQ-041 ld_data falls on the cycle the 32nd beat is accepted -> 32 writes, ld_done pulses for one cycle, init_error=0.
